// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the M-stage exception controller.
// ExcCodes, CP0 field positions, vector constants and FSM states.
package exception_ctrl_pkg;

    // MIPS ExcCode values, plus a private code marking an ERET commit
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_ERET = 5'b11111;

    // CP0 Status / Cause bit positions
    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_BEV = 22;
    localparam int IM_HI  = 15;
    localparam int IM_LO  = 8;
    localparam int IP_HI  = 15;
    localparam int IP_LO  = 8;

    // Exception vector constants
    localparam logic [31:0] VEC_BEV_BASE   = 32'hBFC00200;
    localparam logic [11:0] VEC_OFF_REFILL = 12'h000;
    localparam logic [11:0] VEC_OFF_GEN    = 12'h180;

    // Bit positions inside exc_flagsM
    localparam int F_IF_ADEL       = 9;
    localparam int F_IF_TLB_REFILL = 8;
    localparam int F_IF_TLB_INV    = 7;
    localparam int F_RI            = 6;
    localparam int F_SYS           = 5;
    localparam int F_BP            = 4;
    localparam int F_OV            = 3;
    localparam int F_D_ADEL        = 2;
    localparam int F_D_ADES        = 1;
    localparam int F_D_TLB_REFILL  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_WAIT  = 2'd2
    } exc_state_e;

    // Vector target: BEV selects the boot ROM base, else EBase page
    function automatic logic [31:0] exc_vector(
        input logic        bev,
        input logic [31:0] ebase,
        input logic [11:0] offset
    );
        logic [31:0] base;
        base = bev ? VEC_BEV_BASE : {ebase[31:12], 12'h000};
        return base + {20'h00000, offset};
    endfunction

endpackage

// File: rtl/exception_ctrl_priority.sv
// Fixed-priority exception encoder for the M stage.
// TLB_EXC_EN: when defined, TLB refill/invalid/modify flags participate.
module exc_priority_enc
    import exception_ctrl_pkg::*;
(
    input  logic       int_i,
    input  logic [9:0] flags_i,
    input  logic       d_tlb_inv_i,
    input  logic       d_tlb_mod_i,
    input  logic       eret_i,
    output logic       valid_o,
    output logic [4:0] code_o,
    output logic       fetch_o,
    output logic       data_o,
    output logic       refill_o
);

    logic if_refill;
    logic if_inv;
    logic d_refill;
    logic d_inv;
    logic d_mod;

`ifdef TLB_EXC_EN
    assign if_refill = flags_i[F_IF_TLB_REFILL];
    assign if_inv    = flags_i[F_IF_TLB_INV];
    assign d_refill  = flags_i[F_D_TLB_REFILL];
    assign d_inv     = d_tlb_inv_i;
    assign d_mod     = d_tlb_mod_i;
`else
    logic unused_tlb;
    assign unused_tlb = ^{flags_i[F_IF_TLB_REFILL],
                          flags_i[F_IF_TLB_INV],
                          flags_i[F_D_TLB_REFILL],
                          d_tlb_inv_i, d_tlb_mod_i};
    assign if_refill = 1'b0;
    assign if_inv    = 1'b0;
    assign d_refill  = 1'b0;
    assign d_inv     = 1'b0;
    assign d_mod     = 1'b0;
`endif

    // Highest-priority pending event wins; fetch before decode before data
    always_comb begin
        valid_o  = 1'b1;
        code_o   = EXC_INT;
        fetch_o  = 1'b0;
        data_o   = 1'b0;
        refill_o = 1'b0;
        if (int_i) begin
            code_o = EXC_INT;
        end else if (flags_i[F_IF_ADEL]) begin
            code_o  = EXC_ADEL;
            fetch_o = 1'b1;
        end else if (if_refill || if_inv) begin
            code_o   = EXC_TLBL;
            fetch_o  = 1'b1;
            refill_o = if_refill;
        end else if (flags_i[F_RI]) begin
            code_o = EXC_RI;
        end else if (flags_i[F_SYS]) begin
            code_o = EXC_SYS;
        end else if (flags_i[F_BP]) begin
            code_o = EXC_BP;
        end else if (flags_i[F_OV]) begin
            code_o = EXC_OV;
        end else if (flags_i[F_D_ADEL]) begin
            code_o = EXC_ADEL;
            data_o = 1'b1;
        end else if (flags_i[F_D_ADES]) begin
            code_o = EXC_ADES;
            data_o = 1'b1;
        end else if (d_refill) begin
            code_o   = EXC_TLBL;
            data_o   = 1'b1;
            refill_o = 1'b1;
        end else if (d_inv) begin
            code_o = EXC_TLBS;
            data_o = 1'b1;
        end else if (d_mod) begin
            code_o = EXC_MOD;
            data_o = 1'b1;
        end else if (eret_i) begin
            code_o = EXC_ERET;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// M-stage exception/ERET controller: detect, commit pulse, fetch redirect.
// TLB_EXC_EN: when defined, TLB exceptions and the refill vector are enabled.
module exception_ctrl
    import exception_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallM,
    input  logic        inst_validM,
    input  logic [31:0] pcM,
    input  logic        is_in_delayslotM,
    input  logic [9:0]  exc_flagsM,
    input  logic        d_tlb_invM,
    input  logic        d_tlb_modM,
    input  logic        eretM,
    input  logic [31:0] mem_addrM,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_ebase,
    output logic        flush_exception,
    output logic [4:0]  except_type,
    output logic [31:0] pc_exc,
    output logic [31:0] badvaddr,
    output logic        is_in_delayslot,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    exc_state_e  state_q, state_d;
    logic        flush_q, flush_d;
    logic        rvalid_q, rvalid_d;
    logic [4:0]  type_q, type_d;
    logic [31:0] pc_exc_q, pc_exc_d;
    logic [31:0] bad_q, bad_d;
    logic        ds_q;
    logic [31:0] rpc_q, rpc_d;

    logic        int_pend;
    logic        enc_valid;
    logic [4:0]  enc_code;
    logic        enc_fetch;
    logic        enc_data;
    logic        enc_refill;
    logic        evt;
    logic [11:0] vec_off;
    logic [31:0] vec_pc;

    logic unused_cp0;
    assign unused_cp0 = ^{cp0_status[31:23], cp0_status[21:16],
                          cp0_status[7:2], cp0_cause[31:16],
                          cp0_cause[7:0], cp0_ebase[11:0]};

    assign int_pend = cp0_status[ST_IE] && !cp0_status[ST_EXL] &&
                      (|(cp0_cause[IP_HI:IP_LO] &
                         cp0_status[IM_HI:IM_LO]));

    exc_priority_enc u_enc (
        .int_i       (int_pend),
        .flags_i     (exc_flagsM),
        .d_tlb_inv_i (d_tlb_invM),
        .d_tlb_mod_i (d_tlb_modM),
        .eret_i      (eretM),
        .valid_o     (enc_valid),
        .code_o      (enc_code),
        .fetch_o     (enc_fetch),
        .data_o      (enc_data),
        .refill_o    (enc_refill)
    );

    // Bubbles never raise anything; a pending interrupt simply waits
    assign evt = enc_valid && inst_validM;

`ifdef TLB_EXC_EN
    assign vec_off = (enc_refill && !cp0_status[ST_EXL]) ?
                     VEC_OFF_REFILL : VEC_OFF_GEN;
`else
    logic unused_refill;
    assign unused_refill = enc_refill;
    assign vec_off = VEC_OFF_GEN;
`endif

    assign vec_pc = exc_vector(cp0_status[ST_BEV], cp0_ebase, vec_off);

    // Next state and captured exception record; detection only in IDLE
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        pc_exc_d = pc_exc_q;
        bad_d    = bad_q;
        rpc_d    = rpc_q;
        unique case (state_q)
            S_IDLE: begin
                if (evt && !stallM) begin
                    state_d  = S_FLUSH;
                    type_d   = enc_code;
                    pc_exc_d = pcM;
                    if (enc_fetch) begin
                        bad_d = pcM;
                    end else if (enc_data) begin
                        bad_d = mem_addrM;
                    end
                    rpc_d = (enc_code == EXC_ERET) ? cp0_epc : vec_pc;
                end
            end
            S_FLUSH: begin
                state_d = redirect_ready ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        flush_d  = (state_d == S_FLUSH);
        rvalid_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            flush_q  <= 1'b0;
            rvalid_q <= 1'b0;
            type_q   <= 5'd0;
            pc_exc_q <= 32'h0;
            bad_q    <= 32'h0;
            ds_q     <= 1'b0;
            rpc_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            rvalid_q <= rvalid_d;
            type_q   <= type_d;
            pc_exc_q <= pc_exc_d;
            bad_q    <= bad_d;
            ds_q     <= is_in_delayslotM;
            rpc_q    <= rpc_d;
        end
    end

    assign flush_exception = flush_q;
    assign redirect_valid  = rvalid_q;
    assign except_type     = type_q;
    assign pc_exc          = pc_exc_q;
    assign badvaddr        = bad_q;
    assign is_in_delayslot = ds_q;
    assign redirect_pc     = rpc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: stimulus pushes expected commits,
// a negedge monitor pops and compares on every flush_exception pulse.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallM;
    logic        inst_validM;
    logic [31:0] pcM;
    logic        is_in_delayslotM;
    logic [9:0]  exc_flagsM;
    logic        d_tlb_invM;
    logic        d_tlb_modM;
    logic        eretM;
    logic [31:0] mem_addrM;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_ebase;
    logic        flush_exception;
    logic [4:0]  except_type;
    logic [31:0] pc_exc;
    logic [31:0] badvaddr;
    logic        is_in_delayslot;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    exception_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .stallM           (stallM),
        .inst_validM      (inst_validM),
        .pcM              (pcM),
        .is_in_delayslotM (is_in_delayslotM),
        .exc_flagsM       (exc_flagsM),
        .d_tlb_invM       (d_tlb_invM),
        .d_tlb_modM       (d_tlb_modM),
        .eretM            (eretM),
        .mem_addrM        (mem_addrM),
        .cp0_status       (cp0_status),
        .cp0_cause        (cp0_cause),
        .cp0_epc          (cp0_epc),
        .cp0_ebase        (cp0_ebase),
        .flush_exception  (flush_exception),
        .except_type      (except_type),
        .pc_exc           (pc_exc),
        .badvaddr         (badvaddr),
        .is_in_delayslot  (is_in_delayslot),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  t;
        logic [31:0] pc;
        logic [31:0] bad;
        logic [31:0] rpc;
        logic        ds;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] t, input logic [31:0] pc,
                        input logic [31:0] bad, input logic [31:0] rpc,
                        input logic ds);
        exp_t e;
        e.t = t; e.pc = pc; e.bad = bad; e.rpc = rpc; e.ds = ds;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stallM = 1'b0;
        inst_validM = 1'b1;
        is_in_delayslotM = 1'b0;
        exc_flagsM = 10'h0;
        d_tlb_invM = 1'b0;
        d_tlb_modM = 1'b0;
        eretM = 1'b0;
        mem_addrM = 32'h0;
        cp0_status = 32'h0;
        cp0_cause = 32'h0;
    endtask

    // Monitor: every commit pulse must match the oldest expected record
    always @(negedge clk) begin
        if (flush_exception === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_flush: got type %h pc %h expected none",
                         except_type, pc_exc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("except_type", {27'h0, except_type}, {27'h0, e.t});
                chk("pc_exc", pc_exc, e.pc);
                chk("badvaddr", badvaddr, e.bad);
                chk("redirect_pc", redirect_pc, e.rpc);
                chk("is_in_delayslot", {31'h0, is_in_delayslot}, {31'h0, e.ds});
                chk("redirect_valid_at_flush", {31'h0, redirect_valid}, 32'h1);
            end
        end
    end

    initial begin
        rst = 1'b1;
        clr();
        pcM = 32'h0;
        cp0_epc = 32'h0;
        cp0_ebase = 32'h80000000;
        redirect_ready = 1'b1;
        cyc(); cyc();
        chk("rst_flush", {31'h0, flush_exception}, 32'h0);
        chk("rst_rvalid", {31'h0, redirect_valid}, 32'h0);
        chk("rst_type", {27'h0, except_type}, 32'h0);
        chk("rst_pc_exc", pc_exc, 32'h0);
        chk("rst_badvaddr", badvaddr, 32'h0);
        chk("rst_ds", {31'h0, is_in_delayslot}, 32'h0);
        chk("rst_rpc", redirect_pc, 32'h0);
        rst = 1'b0;
        cyc();

        // Overflow, EBase vector
        pcM = 32'h80001000;
        exc_flagsM[3] = 1'b1;
        push(5'd12, 32'h80001000, 32'h0, 32'h80000180, 1'b0);
        cyc();
        clr();
        cyc();
        chk("rvalid_drop_after_accept", {31'h0, redirect_valid}, 32'h0);
        cyc();

        // ERET returns to EPC
        pcM = 32'h80001100;
        cp0_epc = 32'h80002000;
        eretM = 1'b1;
        push(5'h1f, 32'h80001100, 32'h0, 32'h80002000, 1'b0);
        cyc();
        clr();
        cyc(); cyc();

        // RI + fetch AdEL under stall: held off, then AdEL wins
        pcM = 32'h80003000;
        exc_flagsM[6] = 1'b1;
        exc_flagsM[9] = 1'b1;
        stallM = 1'b1;
        cyc(); cyc();
        stallM = 1'b0;
        push(5'd4, 32'h80003000, 32'h80003000, 32'h80000180, 1'b0);
        cyc();
        clr();
        cyc(); cyc();

        // Data AdES with BEV set
        pcM = 32'h80004000;
        mem_addrM = 32'h12345678;
        cp0_status = 32'h00400000;
        exc_flagsM[1] = 1'b1;
        push(5'd5, 32'h80004000, 32'h12345678, 32'hBFC00380, 1'b0);
        cyc();
        clr();
        cyc(); cyc();

        // Sys beats Bp and Ov; delay slot, badvaddr holds
        pcM = 32'h80004100;
        is_in_delayslotM = 1'b1;
        exc_flagsM[5] = 1'b1;
        exc_flagsM[4] = 1'b1;
        exc_flagsM[3] = 1'b1;
        push(5'd8, 32'h80004100, 32'h12345678, 32'h80000180, 1'b1);
        cyc();
        clr();
        cyc(); cyc();

        // Interrupt pending across three bubbles, taken once valid
        cp0_status = 32'h00008001;
        cp0_cause = 32'h00008000;
        inst_validM = 1'b0;
        pcM = 32'h80005000;
        cyc(); cyc(); cyc();
        inst_validM = 1'b1;
        push(5'd0, 32'h80005000, 32'h12345678, 32'h80000180, 1'b0);
        cyc();
        clr();
        inst_validM = 1'b0;
        cyc(); cyc();
        clr();

        // EXL masks interrupts
        cp0_status = 32'h00008003;
        cp0_cause = 32'h00008000;
        cyc(); cyc();
        clr();
        cyc();

        // Data TLB refill with BEV: refill vector only when enabled
        pcM = 32'h80005100;
        mem_addrM = 32'h00400004;
        cp0_status = 32'h00400000;
        exc_flagsM[0] = 1'b1;
`ifdef TLB_EXC_EN
        push(5'd2, 32'h80005100, 32'h00400004, 32'hBFC00200, 1'b0);
        cyc();
        clr();
        cyc(); cyc();
        chk("tlb_badvaddr", badvaddr, 32'h00400004);
`else
        cyc();
        clr();
        cyc(); cyc();
        chk("tlb_ignored_badvaddr", badvaddr, 32'h12345678);
`endif

        // Slow redirect: one pulse, valid held 5 cycles, pc stable
        pcM = 32'h80006000;
        exc_flagsM[3] = 1'b1;
        redirect_ready = 1'b0;
        push(5'd12, 32'h80006000, badvaddr, 32'h80000180, 1'b0);
        cyc();
        clr();
        exc_flagsM[5] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("hold_rvalid", {31'h0, redirect_valid}, 32'h1);
            chk("hold_rpc", redirect_pc, 32'h80000180);
            if (i == 5) begin
                redirect_ready = 1'b1;
                clr();
            end
            cyc();
        end
        chk("hold_rvalid_end", {31'h0, redirect_valid}, 32'h0);
        cyc(); cyc();

        // Reset while waiting abandons the redirect
        pcM = 32'h80007000;
        exc_flagsM[3] = 1'b1;
        redirect_ready = 1'b0;
        push(5'd12, 32'h80007000, badvaddr, 32'h80000180, 1'b0);
        cyc();
        clr();
        cyc();
        rst = 1'b1;
        cyc();
        chk("wait_rst_rvalid", {31'h0, redirect_valid}, 32'h0);
        chk("wait_rst_rpc", redirect_pc, 32'h0);
        rst = 1'b0;
        redirect_ready = 1'b1;
        cyc(); cyc(); cyc();

        chk("scoreboard_drained", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
